wb_gpio_poller: RTL and testbench
=================================

# wb_gpio_poller

Wishbone initiator that drives the GPIO peripheral from the hardware side: it periodically reads the debounced key inputs at `BASE_ADR+0x00` and emits a change event with both the new key state and a changed-bits mask. It also forwards LED/output-pattern commands as writes to `BASE_ADR+0x04`. It sits between the key-scan/sound logic and the Wishbone GPIO slave, so key handling needs no CPU polling.

## Interface
- `BASE_ADR`, 32'h0000_0000, byte address of the GPIO slave.
- `POLL_DIV`, 50000, clock cycles between poll requests (≥2).
- `TIMEOUT`, 255, maximum cycles a bus cycle waits for ack (≥1).
- `clk` in 1, single clock; all logic on the rising edge.
- `reset` in 1, asynchronous, active-high.
- `wb_cyc_o` out 1, cycle valid.
- `wb_stb_o` out 1, strobe.
- `wb_we_o` out 1, 1 = write.
- `wb_adr_o` out 32, byte address.
- `wb_sel_o` out 4, always 4'hF during a cycle, 4'h0 otherwise.
- `wb_dat_o` out 32, write data.
- `wb_dat_i` in 32, read data.
- `wb_ack_i` in 1, slave acknowledge.
- `led_valid` in 1, LED command offered.
- `led_data` in 7, output pattern.
- `led_ready` out 1, LED command accepted when high with `led_valid`.
- `evt_valid` out 1, key event pending.
- `evt_state` out 13, key state read.
- `evt_changed` out 13, XOR of the new state against the previous state.
- `evt_ready` in 1, event consumed.
- `timeout_err` out 1, one-cycle pulse on bus timeout.

## Operation
- States: IDLE, BUS_RD, BUS_WR, EVT.
- Poll tick: a down-counter loads `POLL_DIV-1` at reset and reloads on reaching 0.
  - Reaching 0 sets `poll_pending`.
  - It runs in every state. Extra ticks while `poll_pending` is already set are absorbed, so at most one poll is pending.
- IDLE:
  - If `poll_pending`: clear it, go to BUS_RD.
  - Else if `led_valid`: latch `led_data`, go to BUS_WR.
  - `led_ready` = (state==IDLE) & ~`poll_pending`. Polls always have priority over LED writes.
- BUS_RD:
  - `cyc`=`stb`=1, `we`=0, `adr`=`BASE_ADR`, `dat_o`=0.
  - On `wb_ack_i`: capture `wb_dat_i[12:0]`; bits 31:13 are ignored.
  - If the capture differs from `prev_state`: load `evt_state`/`evt_changed`, update `prev_state`, go to EVT.
  - Otherwise return to IDLE.
- BUS_WR:
  - `cyc`=`stb`=`we`=1, `adr`=`BASE_ADR+4`, `dat_o`={25'b0, led}.
  - On ack: go to IDLE.
- EVT: hold `evt_valid`=1 with stable data until `evt_ready`, then go to IDLE. Polls accumulate (max one) meanwhile.
- Timeout: a wait counter clears on entering BUS_RD/BUS_WR and increments each cycle without ack.
  - At `TIMEOUT`: drop `cyc`/`stb`, pulse `timeout_err`, discard the data, go to IDLE.
  - `prev_state` is unchanged. A timed-out LED write is dropped, not retried.
- `prev_state` resets to 0, so the first poll with any key pressed produces an event.

## Timing
- Reset values:
  - `cyc`/`stb`/`we` = 0, `adr` = 0, `sel` = 0, `dat_o` = 0.
  - `evt_valid` = 0, `evt_state` = 0, `evt_changed` = 0.
  - `led_ready` = 0 during reset, 1 after reset (IDLE, no poll pending).
  - `timeout_err` = 0.
- All Wishbone outputs are registered.
  - `stb` rises the edge after the IDLE decision.
  - The master samples `ack` on each edge and deasserts `cyc`/`stb` on the same edge it sees ack high.
  - No back-to-back cycles: at least one IDLE cycle separates accesses.
- Against a slave that acks one cycle after `stb`, an access holds `stb` for 2 cycles.
- `evt_valid` rises the edge after a read ack with a change.
- An ack on the same edge as a timeout counts as ack; there is no timeout.
- Asynchronous reset mid-cycle drops `cyc`/`stb` immediately and abandons the cycle.

## Structure
- Shared package `gpio_pkg`:
  - `GPIO_IN_OFS` = 0, `GPIO_OUT_OFS` = 4.
  - `GPIO_IN_W` = 13, `GPIO_OUT_W` = 7.
  - State encoding typedef.
- One natural sub-module: `poll_tick`, a parameterised reloading down-counter that emits a one-cycle tick.

## Test plan
Bench uses `POLL_DIV`=16, `TIMEOUT`=8, and a 1-cycle-ack slave model.
- Slave input 0x0005 after reset → first read at `adr` 0x0, then `evt_valid`, `evt_state`=0x0005, `evt_changed`=0x0005; a second poll with the same value → no event.
- Input changes 0x0005 → 0x0004 → event with `evt_changed`=0x0001; `evt_ready` held low for 40 cycles → `evt_valid` stays high with stable data, exactly one read follows the release.
- `led_valid`, `led_data`=7'h55 in IDLE → write to `adr` 0x4 with `dat_o`=0x55 and `sel`=F, `led_ready` low until back in IDLE.
- Poll tick and `led_valid` in the same cycle → read issued first, LED write immediately after.
- Slave never acks a read → `stb` high for 8 cycles, one-cycle `timeout_err`, no event, next poll proceeds normally.
- Reset asserted while `stb` is high → `cyc`/`stb` low asynchronously; after release, `led_ready`=1 and the first event is relative to 0.

Source files
------------

// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - GPIO register map, port widths and poller state encoding
package gpio_pkg;

   localparam logic [31:0] GPIO_IN_OFS  = 32'h0000_0000;
   localparam logic [31:0] GPIO_OUT_OFS = 32'h0000_0004;

   localparam int GPIO_IN_W  = 13;
   localparam int GPIO_OUT_W = 7;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUS_RD = 2'd1,
      ST_BUS_WR = 2'd2,
      ST_EVT    = 2'd3
   } poll_state_t;

   // Output pattern zero-extended to a full bus word.
   function automatic logic [31:0] out_word(input logic [GPIO_OUT_W-1:0] pattern);
      return {{(32-GPIO_OUT_W){1'b0}}, pattern};
   endfunction

endpackage

// File: rtl/wb_gpio_poller_poll_tick.sv
// rtl/wb_gpio_poller_poll_tick.sv - reloading down-counter emitting a one-cycle tick every DIV clocks
module poll_tick #(
   parameter int DIV = 50000
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int CW = $clog2(DIV);
   localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

   logic [CW-1:0] count;

   // Count down to zero, then reload; zero is the tick cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= RELOAD;
      end else if (count == '0) begin
         count <= RELOAD;
      end else begin
         count <= count - 1'b1;
      end
   end

   assign tick = (count == '0);

endmodule

// File: rtl/wb_gpio_poller.sv
// rtl/wb_gpio_poller.sv - Wishbone initiator polling GPIO keys into change events and forwarding LED writes
module wb_gpio_poller
   import gpio_pkg::*;
#(
   parameter logic [31:0] BASE_ADR = 32'h0000_0000,
   parameter int          POLL_DIV = 50000,
   parameter int          TIMEOUT  = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  wb_cyc_o,
   output logic                  wb_stb_o,
   output logic                  wb_we_o,
   output logic [31:0]           wb_adr_o,
   output logic [3:0]            wb_sel_o,
   output logic [31:0]           wb_dat_o,
   input  logic [31:0]           wb_dat_i,
   input  logic                  wb_ack_i,
   input  logic                  led_valid,
   input  logic [GPIO_OUT_W-1:0] led_data,
   output logic                  led_ready,
   output logic                  evt_valid,
   output logic [GPIO_IN_W-1:0]  evt_state,
   output logic [GPIO_IN_W-1:0]  evt_changed,
   input  logic                  evt_ready,
   output logic                  timeout_err
);

   localparam int WAIT_W = $clog2(TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   poll_state_t           state;
   poll_state_t           state_next;
   logic                  tick;
   logic                  poll_pending;
   logic                  poll_req;
   logic                  poll_take;
   logic                  led_take;
   logic                  timed_out;
   logic                  key_changed;
   logic [WAIT_W-1:0]     wait_cnt;
   logic [GPIO_OUT_W-1:0] led_q;
   logic [GPIO_IN_W-1:0]  prev_state;
   logic [GPIO_IN_W-1:0]  rd_key;
   logic [31-GPIO_IN_W:0] unused_dat;

   poll_tick #(.DIV(POLL_DIV)) u_tick (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   // A tick in the same cycle as the IDLE decision counts as a pending poll,
   // so a coincident LED command can never overtake it.
   assign poll_req    = poll_pending | tick;
   assign rd_key      = wb_dat_i[GPIO_IN_W-1:0];
   assign unused_dat  = wb_dat_i[31:GPIO_IN_W];
   assign key_changed = (rd_key != prev_state);
   assign led_ready   = (state == ST_IDLE) & ~poll_req & ~reset;
   assign evt_valid   = (state == ST_EVT);

   // Next-state decision; ack always wins over an expiring wait counter.
   always_comb begin
      state_next = state;
      poll_take  = 1'b0;
      led_take   = 1'b0;
      timed_out  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (poll_req) begin
               poll_take  = 1'b1;
               state_next = ST_BUS_RD;
            end else if (led_valid) begin
               led_take   = 1'b1;
               state_next = ST_BUS_WR;
            end
         end
         ST_BUS_RD: begin
            if (wb_ack_i) begin
               state_next = key_changed ? ST_EVT : ST_IDLE;
            end else if (wait_cnt == WAIT_LAST) begin
               timed_out  = 1'b1;
               state_next = ST_IDLE;
            end
         end
         ST_BUS_WR: begin
            if (wb_ack_i) begin
               state_next = ST_IDLE;
            end else if (wait_cnt == WAIT_LAST) begin
               timed_out  = 1'b1;
               state_next = ST_IDLE;
            end
         end
         ST_EVT: begin
            if (evt_ready) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // At most one outstanding poll; taking it also absorbs a same-cycle tick.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         poll_pending <= 1'b0;
      end else if (poll_take) begin
         poll_pending <= 1'b0;
      end else if (tick) begin
         poll_pending <= 1'b1;
      end
   end

   // Cycles spent waiting for ack in the current access.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt <= '0;
      end else if ((state != ST_BUS_RD) && (state != ST_BUS_WR)) begin
         wait_cnt <= '0;
      end else if (!wb_ack_i) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   // Hold the accepted LED pattern for the duration of the write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         led_q <= '0;
      end else if (led_take) begin
         led_q <= led_data;
      end
   end

   // Capture a changed key word into the event registers and the reference.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_state  <= '0;
         evt_state   <= '0;
         evt_changed <= '0;
      end else if ((state == ST_BUS_RD) && wb_ack_i && key_changed) begin
         prev_state  <= rd_key;
         evt_state   <= rd_key;
         evt_changed <= rd_key ^ prev_state;
      end
   end

   // Bus outputs registered from the next state, so they drop on the ack edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wb_cyc_o <= 1'b0;
         wb_stb_o <= 1'b0;
         wb_we_o  <= 1'b0;
         wb_adr_o <= '0;
         wb_sel_o <= '0;
         wb_dat_o <= '0;
      end else begin
         case (state_next)
            ST_BUS_RD: begin
               wb_cyc_o <= 1'b1;
               wb_stb_o <= 1'b1;
               wb_we_o  <= 1'b0;
               wb_adr_o <= BASE_ADR + GPIO_IN_OFS;
               wb_sel_o <= 4'hF;
               wb_dat_o <= '0;
            end
            ST_BUS_WR: begin
               wb_cyc_o <= 1'b1;
               wb_stb_o <= 1'b1;
               wb_we_o  <= 1'b1;
               wb_adr_o <= BASE_ADR + GPIO_OUT_OFS;
               wb_sel_o <= 4'hF;
               wb_dat_o <= out_word(led_take ? led_data : led_q);
            end
            default: begin
               wb_cyc_o <= 1'b0;
               wb_stb_o <= 1'b0;
               wb_we_o  <= 1'b0;
               wb_adr_o <= '0;
               wb_sel_o <= '0;
               wb_dat_o <= '0;
            end
         endcase
      end
   end

   // One-cycle pulse when an access is abandoned for lack of ack.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= timed_out;
      end
   end

endmodule

// File: tb/tb_wb_gpio_poller.sv
// tb/tb_wb_gpio_poller.sv - randomized self-checking bench for wb_gpio_poller
module tb_wb_gpio_poller;

   localparam int POLL_DIV = 16;
   localparam int TIMEOUT  = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wb_cyc_o, wb_stb_o, wb_we_o;
   logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
   logic [3:0]  wb_sel_o;
   logic        wb_ack_i;
   logic        led_valid = 1'b0;
   logic [6:0]  led_data = '0;
   logic        led_ready;
   logic        evt_valid;
   logic [12:0] evt_state, evt_changed;
   logic        evt_ready = 1'b0;
   logic        timeout_err;

   wb_gpio_poller #(
      .BASE_ADR (32'h0000_0000),
      .POLL_DIV (POLL_DIV),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .wb_cyc_o    (wb_cyc_o),
      .wb_stb_o    (wb_stb_o),
      .wb_we_o     (wb_we_o),
      .wb_adr_o    (wb_adr_o),
      .wb_sel_o    (wb_sel_o),
      .wb_dat_o    (wb_dat_o),
      .wb_dat_i    (wb_dat_i),
      .wb_ack_i    (wb_ack_i),
      .led_valid   (led_valid),
      .led_data    (led_data),
      .led_ready   (led_ready),
      .evt_valid   (evt_valid),
      .evt_state   (evt_state),
      .evt_changed (evt_changed),
      .evt_ready   (evt_ready),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Slave: acks one cycle after it sees a strobe, when allowed to.
   logic        ack = 1'b0;
   logic        ack_en = 1'b1;
   logic [12:0] key_in = '0;
   logic [18:0] junk = '0;
   assign wb_ack_i = ack;
   assign wb_dat_i = {junk, key_in};

   always @(posedge clk or posedge reset) begin
      if (reset) ack <= 1'b0;
      else       ack <= wb_cyc_o & wb_stb_o & ~ack & ack_en;
   end

   // Reference model: an event is owed for every completed read whose key
   // word differs from the last reported one; writes carry accepted patterns.
   logic [12:0] model_prev = '0;
   logic [25:0] exp_evt[$];
   logic [6:0]  exp_wr[$];
   logic        start_log[$];
   int rd_done = 0, wr_done = 0, rd_start = 0, timeouts = 0;
   int acc_count = 0, evt_count = 0, stb_len = 0, last_len = 0;
   logic        prev_stb = 1'b0, prev_to = 1'b0, prev_done = 1'b0, cur_we = 1'b0;
   logic [31:0] last_wr_dat = '0;

   always @(negedge clk) begin : monitor
      logic [25:0] e;
      if (reset) begin
         model_prev = '0;
         exp_evt.delete();
         exp_wr.delete();
         stb_len  = 0;
         prev_stb = 1'b0;
         prev_to  = 1'b0;
         prev_done = 1'b0;
      end else begin
         if (prev_done) check_eq("gap_after_ack", 32'(wb_cyc_o), 32'd0);
         if (wb_stb_o && !prev_stb) begin
            cur_we = wb_we_o;
            start_log.push_back(wb_we_o);
            if (!wb_we_o) rd_start++;
         end
         if (wb_stb_o) begin
            stb_len++;
            check_eq("sel_active", 32'(wb_sel_o), 32'hF);
            check_eq("led_ready_busy", 32'(led_ready), 32'd0);
            if (wb_we_o) begin
               check_eq("wr_adr", wb_adr_o, 32'h4);
            end else begin
               check_eq("rd_adr", wb_adr_o, 32'h0);
               check_eq("rd_dat_o", wb_dat_o, 32'h0);
            end
         end else begin
            if (prev_stb) last_len = stb_len;
            stb_len = 0;
         end
         prev_done = wb_stb_o & wb_ack_i;
         if (wb_stb_o && wb_ack_i) begin
            if (wb_we_o) begin
               wr_done++;
               last_wr_dat = wb_dat_o;
               check_eq("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
               if (exp_wr.size() != 0) check_eq("wr_dat", wb_dat_o, {25'b0, exp_wr.pop_front()});
            end else begin
               rd_done++;
               if (wb_dat_i[12:0] != model_prev) begin
                  exp_evt.push_back({wb_dat_i[12:0], wb_dat_i[12:0] ^ model_prev});
                  model_prev = wb_dat_i[12:0];
               end
            end
         end
         if (timeout_err) begin
            timeouts++;
            check_eq("timeout_pulse", 32'(prev_to), 32'd0);
            check_eq("timeout_len", 32'(last_len), 32'(TIMEOUT));
            if (cur_we && exp_wr.size() != 0) void'(exp_wr.pop_front());
         end
         prev_to  = timeout_err;
         prev_stb = wb_stb_o;
         if (led_valid && led_ready) begin
            exp_wr.push_back(led_data);
            acc_count++;
         end
         if (evt_valid && evt_ready) begin
            evt_count++;
            check_eq("evt_expected", 32'(exp_evt.size() != 0), 32'd1);
            if (exp_evt.size() != 0) begin
               e = exp_evt.pop_front();
               check_eq("evt_state", 32'(evt_state), 32'(e[25:13]));
               check_eq("evt_changed", 32'(evt_changed), 32'(e[12:0]));
            end
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
         junk = 19'($urandom);
      end
   endtask

   task automatic wait_evt(input string tag, input int max);
      for (int i = 0; i < max && !evt_valid; i++) step();
      check_eq(tag, 32'(evt_valid), 32'd1);
   endtask

   task automatic consume_evt();
      evt_ready = 1'b1;
      step();
      evt_ready = 1'b0;
   endtask

   task automatic wait_count(input string tag, ref int cnt, input int target, input int max);
      for (int i = 0; i < max && cnt < target; i++) step();
      check_eq(tag, 32'(cnt >= target), 32'd1);
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : stim
      int r, w, a, n, acc_seen;
      logic stable;
      logic [12:0] kv[4];
      kv[0] = 13'h0000; kv[1] = 13'h0005; kv[2] = 13'h1A40; kv[3] = 13'h0FFF;

      repeat (3) @(negedge clk);
      check_eq("rst_cyc", 32'(wb_cyc_o), 32'd0);
      check_eq("rst_stb", 32'(wb_stb_o), 32'd0);
      check_eq("rst_we", 32'(wb_we_o), 32'd0);
      check_eq("rst_adr", wb_adr_o, 32'd0);
      check_eq("rst_sel", 32'(wb_sel_o), 32'd0);
      check_eq("rst_dat_o", wb_dat_o, 32'd0);
      check_eq("rst_evt_valid", 32'(evt_valid), 32'd0);
      check_eq("rst_evt_state", 32'(evt_state), 32'd0);
      check_eq("rst_evt_changed", 32'(evt_changed), 32'd0);
      check_eq("rst_led_ready", 32'(led_ready), 32'd0);
      check_eq("rst_timeout_err", 32'(timeout_err), 32'd0);
      @(posedge clk);
      #2 reset = 1'b0;
      step();
      check_eq("post_rst_led_ready", 32'(led_ready), 32'd1);

      // First poll reports the pressed keys relative to zero.
      key_in = 13'h0005;
      r = rd_done;
      wait_evt("t1_evt", 40);
      check_eq("t1_evt_state", 32'(evt_state), 32'h5);
      check_eq("t1_evt_changed", 32'(evt_changed), 32'h5);
      check_eq("t1_one_read", 32'(rd_done - r), 32'd1);
      consume_evt();
      check_eq("t1_evt_cleared", 32'(evt_valid), 32'd0);
      check_eq("t1_stb_len", 32'(last_len), 32'd2);
      r = rd_done;
      wait_count("t1_second_read", rd_done, r + 1, 40);
      step(2);
      check_eq("t1_no_evt_same", 32'(evt_valid), 32'd0);

      // Change with a stalled consumer.
      key_in = 13'h0004;
      wait_evt("t2_evt", 40);
      check_eq("t2_evt_changed", 32'(evt_changed), 32'h1);
      r = rd_start;
      stable = 1'b1;
      for (int i = 0; i < 40; i++) begin
         step();
         if (evt_valid !== 1'b1 || evt_state !== 13'h4 || evt_changed !== 13'h1) stable = 1'b0;
      end
      check_eq("t2_hold_stable", 32'(stable), 32'd1);
      check_eq("t2_no_read_in_evt", 32'(rd_start - r), 32'd0);
      consume_evt();
      r = rd_start;
      step(3);
      check_eq("t2_one_read_after", 32'(rd_start - r), 32'd1);

      // LED write.
      for (int i = 0; i < 40 && !led_ready; i++) step();
      w = wr_done;
      led_valid = 1'b1;
      led_data  = 7'h55;
      step();
      led_valid = 1'b0;
      wait_count("t3_write_done", wr_done, w + 1, 20);
      check_eq("t3_wr_dat", last_wr_dat, 32'h55);

      // Pending poll and LED command meet in IDLE: read goes first.
      key_in = 13'h0100;
      wait_evt("t4_evt", 40);
      step(20);
      led_valid = 1'b1;
      led_data  = 7'h2A;
      n = start_log.size();
      a = acc_count;
      w = wr_done;
      consume_evt();
      wait_count("t4_led_accept", acc_count, a + 1, 20);
      led_valid = 1'b0;
      wait_count("t4_write_done", wr_done, w + 1, 20);
      check_eq("t4_read_first", 32'(start_log.size() > n + 1 ? start_log[n] : 1'b1), 32'd0);
      check_eq("t4_write_second", 32'(start_log.size() > n + 1 ? start_log[n+1] : 1'b0), 32'd1);
      check_eq("t4_wr_dat", last_wr_dat, 32'h2A);

      // Read never acked.
      r = rd_done;
      wait_count("t5_sync_read", rd_done, r + 1, 40);
      ack_en = 1'b0;
      key_in = 13'h1FFF;
      a = timeouts;
      wait_count("t5_timeout", timeouts, a + 1, 60);
      step();
      check_eq("t5_no_evt", 32'(evt_valid), 32'd0);
      ack_en = 1'b1;
      wait_evt("t5_next_evt", 40);
      check_eq("t5_evt_changed", 32'(evt_changed), 32'h1EFF);
      consume_evt();

      // Reset in the middle of an access.
      ack_en = 1'b0;
      for (int i = 0; i < 40 && !wb_stb_o; i++) step();
      #1 reset = 1'b1;
      #1;
      check_eq("t6_cyc_async", 32'(wb_cyc_o), 32'd0);
      check_eq("t6_stb_async", 32'(wb_stb_o), 32'd0);
      ack_en = 1'b1;
      key_in = 13'h0A0A;
      step(2);
      reset = 1'b0;
      step();
      check_eq("t6_led_ready", 32'(led_ready), 32'd1);
      wait_evt("t6_evt", 40);
      check_eq("t6_evt_changed", 32'(evt_changed), 32'h0A0A);
      consume_evt();

      // Randomized traffic against the reference model.
      acc_seen = acc_count;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 19) == 0) key_in = kv[$urandom_range(0, 3)];
         evt_ready = ($urandom_range(0, 2) != 0);
         ack_en    = ($urandom_range(0, 3) != 0);
         if (!led_valid || acc_count != acc_seen) begin
            acc_seen  = acc_count;
            led_valid = ($urandom_range(0, 9) == 0);
            led_data  = 7'($urandom);
         end
         step();
      end
      led_valid = 1'b0;
      evt_ready = 1'b1;
      ack_en    = 1'b1;
      step(60);
      check_eq("drain_evt_queue", 32'(exp_evt.size()), 32'd0);
      check_eq("drain_wr_queue", 32'(exp_wr.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
